// File: rtl/arith_pkg.sv
// Shared types for the arith_arbiter slice: FSM states, flag bundle
// and the default datapath width.
package arith_pkg;

  localparam int ARITH_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RSP
  } arb_state_e;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic negative;
  } arith_flags_t;

endpackage

// File: rtl/arith_unit.sv
// Shared adder with signed-overflow, carry-out and negative flags.
module arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output arith_flags_t     o_flags
);

  logic [WIDTH:0] w_sum;

  assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
  assign o_result = w_sum[WIDTH-1:0];

  always_comb begin
    o_flags          = '0;
    o_flags.carry    = w_sum[WIDTH];
    o_flags.negative = w_sum[WIDTH-1];
    o_flags.overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from last+1 upward with
// wrap-around and returns a one-hot grant plus its index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = {1'b0, i_last} + (ID_W+1)'(i);
      if (w_k >= (ID_W+1)'(NUM_REQ))
        w_k = w_k - (ID_W+1)'(NUM_REQ);
      if (!o_any && i_req[w_k[ID_W-1:0]]) begin
        o_any                 = 1'b1;
        o_idx                 = w_k[ID_W-1:0];
        o_gnt[w_k[ID_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_arbiter.sv
// Round-robin sequencer sharing one arith_unit among NUM_REQ clients.
// Define ARITH_ARB_PERF_EN to add per-requester grant counters.
module arith_arbiter
  import arith_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ARITH_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_overflow,
  output logic                     rsp_carry,
  output logic                     rsp_negative
`ifdef ARITH_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]    perf_grants
`endif
);

  arb_state_e         r_state;
  arb_state_e         w_next;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_rsp_id;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic               w_accept;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]   r_result;
  arith_flags_t       w_flags;
  arith_flags_t       r_flags;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  arith_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  assign w_accept = (r_state == ARB_IDLE) && w_any;
  // Gate with rst_n so no grant leaks out while reset is held.
  assign req_ready = (rst_n && r_state == ARB_IDLE) ? w_gnt : '0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_any)     w_next = ARB_EXEC;
      ARB_EXEC:                w_next = ARB_RSP;
      ARB_RSP:  if (rsp_ready) w_next = ARB_IDLE;
      default:                 w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_last  <= ID_W'(NUM_REQ-1);
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last <= w_idx;
        r_id   <= w_idx;
        r_a    <= req_a[w_idx*WIDTH +: WIDTH];
        r_b    <= req_b[w_idx*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_rsp_id <= '0;
    end else if (r_state == ARB_EXEC) begin
      r_result <= w_result;
      r_flags  <= w_flags;
      r_rsp_id <= r_id;
    end
  end

  assign rsp_valid    = (r_state == ARB_RSP);
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_result;
  assign rsp_overflow = r_flags.overflow;
  assign rsp_carry    = r_flags.carry;
  assign rsp_negative = r_flags.negative;

`ifdef ARITH_ARB_PERF_EN
  logic [15:0] r_perf [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++)
        r_perf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_accept && w_gnt[i] && r_perf[i] != 16'hFFFF)
          r_perf[i] <= r_perf[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_grants[g*16 +: 16] = r_perf[g];
  end
`endif

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed self-checking bench for arith_arbiter.
`timescale 1ns/1ps
module tb_arith_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*W-1:0] req_a = '0;
  logic [NR*W-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [IW-1:0] rsp_id;
  logic [W-1:0]  rsp_result;
  logic          rsp_overflow;
  logic          rsp_carry;
  logic          rsp_negative;
`ifdef ARITH_ARB_PERF_EN
  logic [NR*16-1:0] perf_grants;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arith_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_carry    (rsp_carry),
    .rsp_negative (rsp_negative)
`ifdef ARITH_ARB_PERF_EN
    ,
    .perf_grants  (perf_grants)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    checks++;
    if ({rsp_id, rsp_result} !== 34'd0) begin
      errors++;
      $display("FAIL reset_rsp_fields: got id=%0d res=%h want 0/0",
               rsp_id, rsp_result);
    end
    checks++;
    if ({rsp_overflow, rsp_carry, rsp_negative} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b want 000",
               rsp_overflow, rsp_carry, rsp_negative);
    end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_op(2, 32'h0000_0005, 32'h0000_0003);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if ({rsp_valid, req_ready} !== 5'b0_0000) begin
      errors++;
      $display("FAIL single_exec: got v=%b rdy=%b want 0/0000",
               rsp_valid, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d want 1/2",
               rsp_valid, rsp_id);
    end
    checks++;
    if (rsp_result !== 32'd8 ||
        {rsp_overflow, rsp_carry, rsp_negative} !== 3'b000) begin
      errors++;
      $display("FAIL single_result: got %h %b%b%b want 00000008 000",
               rsp_result, rsp_overflow, rsp_carry, rsp_negative);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd8) begin
      errors++;
      $display("FAIL single_hold: got v=%b res=%h want 1/8",
               rsp_valid, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_consume: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_flags();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    logic [W-1:0] tr [2];
    logic [2:0]   tf [2];
    ta[0] = 32'h7FFF_FFFF; tb[0] = 32'h0000_0001;
    tr[0] = 32'h8000_0000; tf[0] = 3'b101;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;
    tr[1] = 32'hFFFF_FFFE; tf[1] = 3'b011;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_op(3, ta[k], tb[k]);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 ||
          rsp_result !== tr[k]) begin
        errors++;
        $display("FAIL flags_result%0d: got v=%b id=%0d res=%h want 1/3/%h",
                 k, rsp_valid, rsp_id, rsp_result, tr[k]);
      end
      checks++;
      if ({rsp_overflow, rsp_carry, rsp_negative} !== tf[k]) begin
        errors++;
        $display("FAIL flags_vcn%0d: got %b%b%b want %b", k,
                 rsp_overflow, rsp_carry, rsp_negative, tf[k]);
      end
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_fairness();
    int n;
    int cyc;
    int last_cyc;
    n = 0;
    cyc = 0;
    last_cyc = 0;
    for (int i = 0; i < NR; i++)
      set_op(i, 32'(i), 32'd100);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 40 && n < 8; c++) begin
      tick();
      cyc++;
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== 2'(n % 4) || rsp_result !== 32'(100 + n % 4)) begin
          errors++;
          $display("FAIL fair_rsp%0d: got id=%0d res=%0d want %0d/%0d",
                   n, rsp_id, rsp_result, n % 4, 100 + n % 4);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL fair_gap%0d: got %0d want 3", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n++;
        if (n == 8) req_valid = '0;
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL fair_timeout: got %0d responses want 8", n);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [1+IW+W+3+NR-1:0] want;
    logic [1+IW+W+3+NR-1:0] got;
    set_op(0, 32'h8000_0000, 32'h8000_0001);
    set_op(1, 32'h0000_0010, 32'h0000_0020);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    tick();
    tick();
    want = {1'b1, 2'd0, 32'h0000_0001, 3'b110, 4'b0000};
    for (int c = 0; c < 10; c++) begin
      got = {rsp_valid, rsp_id, rsp_result,
             rsp_overflow, rsp_carry, rsp_negative, req_ready};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h want %h", c, got, want);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_next_grant: got %b want 0010", req_ready);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_withdraw: got %b want 0000", req_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, req_ready} !== 5'b0_0000) begin
      errors++;
      $display("FAIL bp_no_stale: got v=%b rdy=%b want 0/0000",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NR; i++)
      set_op(i, 32'(i + 1), 32'd7);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 ||
        req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_clear: got v=%b res=%h rdy=%b want 0/0/0000",
               rsp_valid, rsp_result, req_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_first: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd8) begin
      errors++;
      $display("FAIL rstmid_rsp: got v=%b id=%0d res=%0d want 1/0/8",
               rsp_valid, rsp_id, rsp_result);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

`ifdef ARITH_ARB_PERF_EN
  task automatic test_perf();
    int n;
    n = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    for (int c = 0; c < 100 && n < 20; c++) begin
      #1;
      if (req_ready[1]) begin
        n++;
        tick();
        if (n == 20) req_valid = '0;
      end else begin
        tick();
      end
    end
    repeat (3) tick();
    rsp_ready = 1'b0;
    checks++;
    if (perf_grants !== {16'd0, 16'd0, 16'd20, 16'd0}) begin
      errors++;
      $display("FAIL perf_count: got %h want 0000000000140000", perf_grants);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef ARITH_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
